// File: rtl/demux_32_bit_buffered_pkg.sv
// ============================================================================
// Module  : demux_32_bit_buffered_pkg
// Brief   : Shared constants and types for the buffered 1-to-2 word demux.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package demux_32_bit_buffered_pkg;

    localparam int   WORD_WIDTH  = 32;
    localparam logic LANE_0      = 1'b0;
    localparam logic LANE_1      = 1'b1;
    localparam int   COUNT_WIDTH = 16;
    localparam int   NUM_LANES   = 2;

    // Per-lane handshake status seen by the steering logic
    typedef struct packed {
        logic full;
        logic valid;
    } lane_status_t;

    function automatic int fill_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/demux_lane_fifo.sv
// ============================================================================
// Module  : demux_lane_fifo
// Brief   : Per-lane FIFO; head word is read straight from registered storage.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module demux_lane_fifo
    import demux_32_bit_buffered_pkg::*;
#(
    parameter int WIDTH = WORD_WIDTH,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             head_valid,
    output logic             full
);

    localparam int c_PTR_W  = $clog2(DEPTH);
    localparam int c_FILL_W = fill_width(DEPTH);

    logic [WIDTH-1:0]    r_mem [DEPTH];
    logic [c_PTR_W-1:0]  r_wr_ptr;
    logic [c_PTR_W-1:0]  r_rd_ptr;
    logic [c_FILL_W-1:0] r_fill;

    logic w_push_ok;
    logic w_pop_ok;

    // Guards keep the fill count within [0, DEPTH] even on a misbehaving caller
    assign w_push_ok = push && !full;
    assign w_pop_ok  = pop && head_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_fill   <= '0;
        end else begin
            if (w_push_ok) begin
                r_mem[r_wr_ptr] <= push_data;
                r_wr_ptr        <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_fill <= r_fill + c_FILL_W'(1);
                2'b01:   r_fill <= r_fill - c_FILL_W'(1);
                default: r_fill <= r_fill;
            endcase
        end
    end

    assign head_data  = r_mem[r_rd_ptr];
    assign head_valid = (r_fill != '0);
    assign full       = (r_fill == c_FILL_W'(DEPTH));

endmodule

`default_nettype wire

// File: rtl/demux_32_bit_buffered.sv
// ============================================================================
// Module  : demux_32_bit_buffered
// Brief   : 1-to-2 valid/ready word steering with a FIFO per output lane.
//           Optional accepted-word counters enabled by DEMUX_COUNT_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module demux_32_bit_buffered
    import demux_32_bit_buffered_pkg::*;
#(
    parameter int WIDTH = WORD_WIDTH,
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [WIDTH-1:0]       in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   select,
    output logic [WIDTH-1:0]       out_0,
    output logic                   out_0_valid,
    input  logic                   out_0_ready,
    output logic [WIDTH-1:0]       out_1,
    output logic                   out_1_valid,
    input  logic                   out_1_ready
`ifdef DEMUX_COUNT_EN
    ,
    output logic [COUNT_WIDTH-1:0] count_0,
    output logic [COUNT_WIDTH-1:0] count_1
`endif
);

    lane_status_t     w_status [NUM_LANES];
    logic [WIDTH-1:0] w_head   [NUM_LANES];
    logic             w_push   [NUM_LANES];
    logic             w_pop    [NUM_LANES];
    logic             w_accept;

    // Registered fill only: a same-cycle pop never opens in_ready
    assign in_ready = !w_status[select].full;
    assign w_accept = in_valid && in_ready;

    assign w_pop[0] = w_status[0].valid && out_0_ready;
    assign w_pop[1] = w_status[1].valid && out_1_ready;

    generate
        for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
            assign w_push[g] = w_accept && (select == 1'(g));

            demux_lane_fifo #(
                .WIDTH (WIDTH),
                .DEPTH (DEPTH)
            ) u_fifo (
                .clk        (clk),
                .rst        (rst),
                .push       (w_push[g]),
                .push_data  (in_data),
                .pop        (w_pop[g]),
                .head_data  (w_head[g]),
                .head_valid (w_status[g].valid),
                .full       (w_status[g].full)
            );
        end
    endgenerate

    assign out_0       = w_head[0];
    assign out_0_valid = w_status[0].valid;
    assign out_1       = w_head[1];
    assign out_1_valid = w_status[1].valid;

`ifdef DEMUX_COUNT_EN
    logic [COUNT_WIDTH-1:0] r_count_0;
    logic [COUNT_WIDTH-1:0] r_count_1;

    // Counters wrap naturally at 2**COUNT_WIDTH
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count_0 <= '0;
            r_count_1 <= '0;
        end else begin
            if (w_accept && (select == LANE_0)) begin
                r_count_0 <= r_count_0 + COUNT_WIDTH'(1);
            end
            if (w_accept && (select == LANE_1)) begin
                r_count_1 <= r_count_1 + COUNT_WIDTH'(1);
            end
        end
    end

    assign count_0 = r_count_0;
    assign count_1 = r_count_1;
`endif

endmodule

`default_nettype wire

// File: tb/tb_demux_32_bit_buffered.sv
// ============================================================================
// Module  : tb_demux_32_bit_buffered
// Brief   : Scoreboard bench for demux_32_bit_buffered (DEMUX_COUNT_EN aware).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_demux_32_bit_buffered;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        select = 1'b0;
    logic [31:0] out_0;
    logic        out_0_valid;
    logic        out_0_ready = 1'b0;
    logic [31:0] out_1;
    logic        out_1_valid;
    logic        out_1_ready = 1'b0;
`ifdef DEMUX_COUNT_EN
    logic [15:0] count_0;
    logic [15:0] count_1;
    logic [15:0] cnt_m [2];
`endif

    demux_32_bit_buffered #(.WIDTH(32), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .select      (select),
        .out_0       (out_0),
        .out_0_valid (out_0_valid),
        .out_0_ready (out_0_ready),
        .out_1       (out_1),
        .out_1_valid (out_1_valid),
        .out_1_ready (out_1_ready)
`ifdef DEMUX_COUNT_EN
        ,
        .count_0     (count_0),
        .count_1     (count_1)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: one queue per lane holding accepted, not-yet-consumed words
    logic [31:0] q0[$];
    logic [31:0] q1[$];
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: inputs are driven at negedge+1, so negedge+2 sees a settled handshake
    initial begin
        forever begin
            @(negedge clk);
            #2;
            check("out_0_valid", 32'(out_0_valid), 32'(q0.size() != 0));
            if (q0.size() != 0) begin
                check("out_0_data", out_0, q0[0]);
                if (out_0_ready) void'(q0.pop_front());
            end
            check("out_1_valid", 32'(out_1_valid), 32'(q1.size() != 0));
            if (q1.size() != 0) begin
                check("out_1_data", out_1, q1[0]);
                if (out_1_ready) void'(q1.pop_front());
            end
        end
    end

    // One clock of stimulus; acceptance is decided by the model's lane occupancy
    task automatic cycle(input logic v, input logic sel, input logic [31:0] d,
                         input logic r0, input logic r1);
        logic exp_ready;
        @(negedge clk);
        #1;
        exp_ready   = ((sel ? q1.size() : q0.size()) < DEPTH);
        in_valid    = v;
        select      = sel;
        in_data     = d;
        out_0_ready = r0;
        out_1_ready = r1;
        #2;
        check("in_ready", 32'(in_ready), 32'(exp_ready));
        if (v && exp_ready) begin
            if (sel) q1.push_back(d);
            else     q0.push_back(d);
`ifdef DEMUX_COUNT_EN
            cnt_m[sel] = cnt_m[sel] + 16'd1;
`endif
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && (q0.size() != 0 || q1.size() != 0); i++) begin
            cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        end
        cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        check("drain_empty", 32'(q0.size() + q1.size()), 32'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
`ifdef DEMUX_COUNT_EN
        cnt_m[0] = '0;
        cnt_m[1] = '0;
`endif
        // Reset state
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_out_0_valid", 32'(out_0_valid), 32'd0);
        check("rst_out_1_valid", 32'(out_1_valid), 32'd0);
        check("rst_out_0", out_0, 32'd0);
        check("rst_out_1", out_1, 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // Single word to lane 0
        cycle(1'b1, 1'b0, 32'hAAAA_AAAA, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        drain();

        // Lane 1 fills while stalled; lane 0 still accepts
        cycle(1'b1, 1'b1, 32'h1, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 32'h2, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 32'h3, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 32'h3, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        drain();

        // Full lane 0 with same-cycle pop: push waits one cycle
        cycle(1'b1, 1'b0, 32'h10, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 32'h11, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 32'h12, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 32'h12, 1'b0, 1'b0);
        drain();

        // Asynchronous reset between edges with lane 1 full
        cycle(1'b1, 1'b1, 32'h20, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 32'h21, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        in_valid = 1'b0;
        rst      = 1'b1;
        q0.delete();
        q1.delete();
`ifdef DEMUX_COUNT_EN
        cnt_m[0] = '0;
        cnt_m[1] = '0;
`endif
        #1;
        check("arst_out_1_valid", 32'(out_1_valid), 32'd0);
        check("arst_out_1", out_1, 32'd0);
        check("arst_in_ready", 32'(in_ready), 32'd1);
        #1;
        rst = 1'b0;
        cycle(1'b1, 1'b1, 32'h22, 1'b1, 1'b1);
        cycle(1'b0, 1'b1, 32'h0, 1'b1, 1'b1);
        drain();

        // Randomized traffic with varying consumer back-pressure
        for (int i = 0; i < 600; i++) begin
            cycle(1'($urandom_range(0, 3) != 0), 1'($urandom), $urandom,
                  1'($urandom_range(0, 3) < (i % 4)), 1'($urandom_range(0, 3) < ((i / 4) % 4)));
        end
        drain();

`ifdef DEMUX_COUNT_EN
        check("count_0_model", 32'(count_0), 32'(cnt_m[0]));
        check("count_1_model", 32'(count_1), 32'(cnt_m[1]));

        @(negedge clk);
        rst = 1'b1;
        cnt_m[0] = '0;
        cnt_m[1] = '0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 65537; i++) begin
            cycle(1'b1, 1'b0, 32'(i), 1'b1, 1'b0);
        end
        drain();
        check("count_0_wrap", 32'(count_0), 32'd1);
        check("count_1_idle", 32'(count_1), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
